// File: rtl/model_stream_reader.sv
// Walks one stored model triangle by triangle and streams it downstream over valid/ready.
// Optional MODEL_STREAM_READER_STATS_EN adds handshake and stall counters.
module model_stream_reader #(
    parameter int MAX_MODEL_COUNT    = 10,
    parameter int MAX_TRIANGLE_COUNT = 100,
    parameter int TRIANGLE_W         = 156,
    localparam int MIW = (MAX_MODEL_COUNT > 1) ? $clog2(MAX_MODEL_COUNT) : 1,
    localparam int TIW = (MAX_TRIANGLE_COUNT > 1) ? $clog2(MAX_TRIANGLE_COUNT) : 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [MIW-1:0]        cmd_model_index,
    output logic [MIW-1:0]        read_model_index,
    output logic [TIW-1:0]        read_triangle_index,
    input  logic [TRIANGLE_W-1:0] read_triangle,
    input  logic                  read_last_index,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [TRIANGLE_W-1:0] out_triangle,
    output logic                  out_last,
    output logic                  done
`ifdef MODEL_STREAM_READER_STATS_EN
    ,
    output logic [15:0]           stat_triangles,
    output logic [15:0]           stat_stall_cycles
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1
    } state_e;

    localparam logic [TIW-1:0] LAST_IDX = TIW'(MAX_TRIANGLE_COUNT - 1);

    state_e                  state_q, state_d;
    logic [MIW-1:0]          model_q, model_d;
    logic [TIW-1:0]          count_q, count_d;
    logic                    fetched_q, fetched_d;
    logic                    out_valid_q, out_valid_d;
    logic [TRIANGLE_W-1:0]   out_tri_q, out_tri_d;
    logic                    out_last_q, out_last_d;
    logic                    done_q, done_d;

    logic                    capture;
    logic                    last_tri;
    logic                    accept;

    // The index guard terminates the walk even if the buffer never flags a last triangle.
    assign last_tri = read_last_index || (count_q == LAST_IDX);
    assign capture  = (state_q == ST_STREAM) && !fetched_q && (!out_valid_q || out_ready);
    assign accept   = (state_q == ST_IDLE) && cmd_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            model_q     <= '0;
            count_q     <= '0;
            fetched_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_tri_q   <= '0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            model_q     <= model_d;
            count_q     <= count_d;
            fetched_q   <= fetched_d;
            out_valid_q <= out_valid_d;
            out_tri_q   <= out_tri_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        model_d     = model_q;
        count_d     = count_q;
        fetched_d   = fetched_q;
        out_valid_d = out_valid_q;
        out_tri_d   = out_tri_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    model_d   = cmd_model_index;
                    count_d   = '0;
                    fetched_d = 1'b0;
                    state_d   = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (capture) begin
                    out_tri_d   = read_triangle;
                    out_valid_d = 1'b1;
                    out_last_d  = last_tri;
                    if (last_tri) begin
                        fetched_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end else if (fetched_q && out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    done_d      = 1'b1;
                    state_d     = ST_IDLE;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                fetched_d   = 1'b0;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    // cmd_ready is gated by rstn so it reads low while reset is held.
    assign cmd_ready           = rstn && (state_q == ST_IDLE);
    assign read_model_index    = model_q;
    assign read_triangle_index = count_q;
    assign out_valid           = out_valid_q;
    assign out_triangle        = out_tri_q;
    assign out_last            = out_last_q;
    assign done                = done_q;

`ifdef MODEL_STREAM_READER_STATS_EN
    logic [15:0] stat_tri_q;
    logic [15:0] stat_stall_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_tri_q   <= '0;
            stat_stall_q <= '0;
        end else if (accept) begin
            stat_tri_q   <= '0;
            stat_stall_q <= '0;
        end else begin
            if (out_valid_q && out_ready && (stat_tri_q != 16'hFFFF)) begin
                stat_tri_q <= stat_tri_q + 16'd1;
            end
            if (out_valid_q && !out_ready && (stat_stall_q != 16'hFFFF)) begin
                stat_stall_q <= stat_stall_q + 16'd1;
            end
        end
    end

    assign stat_triangles    = stat_tri_q;
    assign stat_stall_cycles = stat_stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_model_stream_reader.sv
// Directed bench for model_stream_reader with a small combinational model-buffer stand-in.
// Stat checks are compiled in when MODEL_STREAM_READER_STATS_EN is defined.
module tb_model_stream_reader;

    localparam int MMC = 10;
    localparam int MTC = 100;
    localparam int TW  = 156;

    logic           clk = 1'b0;
    logic           rstn;
    logic           cmd_valid;
    logic           cmd_ready;
    logic [3:0]     cmd_model_index;
    logic [3:0]     read_model_index;
    logic [6:0]     read_triangle_index;
    logic [TW-1:0]  read_triangle;
    logic           read_last_index;
    logic           out_valid;
    logic           out_ready;
    logic [TW-1:0]  out_triangle;
    logic           out_last;
    logic           done;
`ifdef MODEL_STREAM_READER_STATS_EN
    logic [15:0]    stat_triangles;
    logic [15:0]    stat_stall_cycles;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    model_stream_reader #(
        .MAX_MODEL_COUNT    (MMC),
        .MAX_TRIANGLE_COUNT (MTC),
        .TRIANGLE_W         (TW)
    ) dut (
        .clk                 (clk),
        .rstn                (rstn),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_model_index     (cmd_model_index),
        .read_model_index    (read_model_index),
        .read_triangle_index (read_triangle_index),
        .read_triangle       (read_triangle),
        .read_last_index     (read_last_index),
        .out_valid           (out_valid),
        .out_ready           (out_ready),
        .out_triangle        (out_triangle),
        .out_last            (out_last),
        .done                (done)
`ifdef MODEL_STREAM_READER_STATS_EN
        ,
        .stat_triangles      (stat_triangles),
        .stat_stall_cycles   (stat_stall_cycles)
`endif
    );

    // Buffer contents: model 2 = 3 triangles, 3 = 2, 5 = 1, 7 = size 0 (never flags last).
    function automatic int model_size(input logic [3:0] m);
        case (m)
            4'd2:    return 3;
            4'd3:    return 2;
            4'd5:    return 1;
            4'd7:    return 0;
            default: return 4;
        endcase
    endfunction

    function automatic logic [TW-1:0] tri_val(input logic [3:0] m, input logic [6:0] i);
        return {m, 8'hA5, 132'd0, 12'(i) + 12'd1};
    endfunction

    always_comb begin
        read_triangle   = tri_val(read_model_index, read_triangle_index);
        read_last_index = (model_size(read_model_index) != 0) &&
                          (int'(read_triangle_index) == model_size(read_model_index) - 1);
    end

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic v, input logic [11:0] color,
                              input logic last, input logic dn);
        check({tag, ".valid"}, out_valid, v);
        if (v) check({tag, ".color"}, out_triangle[11:0], color);
        check({tag, ".last"}, out_last, last);
        check({tag, ".done"}, done, dn);
    endtask

    task automatic issue_cmd(input logic [3:0] m);
        check("cmd_ready_idle", cmd_ready, 1'b1);
        cmd_valid       = 1'b1;
        cmd_model_index = m;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int max_idx;
        int last_at;
        bit done_seen;
        logic [11:0] last_color;

        rstn            = 1'b0;
        cmd_valid       = 1'b0;
        cmd_model_index = '0;
        out_ready       = 1'b1;

        repeat (2) tick();
        check("rst.out_valid", out_valid, 1'b0);
        check("rst.out_triangle", out_triangle, '0);
        check("rst.out_last", out_last, 1'b0);
        check("rst.done", done, 1'b0);
        check("rst.cmd_ready", cmd_ready, 1'b0);
        check("rst.read_model_index", read_model_index, 4'd0);
        check("rst.read_triangle_index", read_triangle_index, 7'd0);
        #2 rstn = 1'b1;
        #1 check("rst.cmd_ready_release", cmd_ready, 1'b1);
        tick();

        // Basic stream of model 2 with no back-pressure.
        issue_cmd(4'd2);
        expect_out("t1.acc", 1'b0, 12'h000, 1'b0, 1'b0);
        check("t1.cmd_ready_busy", cmd_ready, 1'b0);
        check("t1.read_model_index", read_model_index, 4'd2);
        check("t1.read_tri_idx0", read_triangle_index, 7'd0);
        tick(); expect_out("t1.o0", 1'b1, 12'h001, 1'b0, 1'b0);
        check("t1.tri0_full", out_triangle, tri_val(4'd2, 7'd0));
        tick(); expect_out("t1.o1", 1'b1, 12'h002, 1'b0, 1'b0);
        tick(); expect_out("t1.o2", 1'b1, 12'h003, 1'b1, 1'b0);
        tick(); expect_out("t1.done", 1'b0, 12'h000, 1'b0, 1'b1);
        check("t1.cmd_ready_back", cmd_ready, 1'b1);
        tick(); check("t1.done_pulse_end", done, 1'b0);
        $display("stream model 2: plain, 3 triangles");

        // Back-pressure on the first triangle for four cycles.
        out_ready = 1'b0;
        issue_cmd(4'd2);
        expect_out("t2.acc", 1'b0, 12'h000, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_out("t2.hold", 1'b1, 12'h001, 1'b0, 1'b0);
            check("t2.hold_idx", read_triangle_index, 7'd1);
        end
        out_ready = 1'b1;
        tick(); expect_out("t2.o1", 1'b1, 12'h002, 1'b0, 1'b0);
        tick(); expect_out("t2.o2", 1'b1, 12'h003, 1'b1, 1'b0);
        tick(); expect_out("t2.done", 1'b0, 12'h000, 1'b0, 1'b1);
`ifdef MODEL_STREAM_READER_STATS_EN
        check("t2.stat_triangles", stat_triangles, 16'd3);
        check("t2.stat_stall_cycles", stat_stall_cycles, 16'd4);
`endif
        tick();
        $display("stream model 2: back-pressured, 3 triangles");

        // Single-triangle model.
        issue_cmd(4'd5);
        expect_out("t3.acc", 1'b0, 12'h000, 1'b0, 1'b0);
        tick(); expect_out("t3.o0", 1'b1, 12'h001, 1'b1, 1'b0);
        tick(); expect_out("t3.done", 1'b0, 12'h000, 1'b0, 1'b1);
        tick();
        $display("stream model 5: 1 triangle");

        // Size-0 model relies on the index guard.
        n = 0; max_idx = 0; last_at = 0; done_seen = 1'b0; last_color = '0;
        issue_cmd(4'd7);
        for (int c = 0; c < 150 && !done_seen; c++) begin
            tick();
            if (int'(read_triangle_index) > max_idx) max_idx = int'(read_triangle_index);
            if (done) begin
                done_seen = 1'b1;
            end else if (out_valid) begin
                n++;
                last_color = out_triangle[11:0];
                if (out_last && last_at == 0) last_at = n;
            end
        end
        check("t4.done_seen", done_seen, 1'b1);
        check("t4.count", n, 100);
        check("t4.last_at", last_at, 100);
        check("t4.max_idx", max_idx, 99);
        check("t4.last_color", last_color, 12'h064);
        tick();
        $display("stream model 7: %0d triangles (guarded)", n);

        // A held command with a changed index is ignored until the stream completes.
        cmd_valid       = 1'b1;
        cmd_model_index = 4'd2;
        tick();
        cmd_model_index = 4'd5;
        check("t5.cmd_ready_busy", cmd_ready, 1'b0);
        tick(); expect_out("t5.o0", 1'b1, 12'h001, 1'b0, 1'b0);
        check("t5.model_hold0", read_model_index, 4'd2);
        tick(); expect_out("t5.o1", 1'b1, 12'h002, 1'b0, 1'b0);
        check("t5.model_hold1", read_model_index, 4'd2);
        tick(); expect_out("t5.o2", 1'b1, 12'h003, 1'b1, 1'b0);
        check("t5.tri2_full", out_triangle, tri_val(4'd2, 7'd2));
        tick(); expect_out("t5.done", 1'b0, 12'h000, 1'b0, 1'b1);
        tick();
        check("t5.second_model", read_model_index, 4'd5);
        check("t5.second_busy", cmd_ready, 1'b0);
        cmd_valid = 1'b0;
        tick(); expect_out("t5.s0", 1'b1, 12'h001, 1'b1, 1'b0);
        check("t5.s0_full", out_triangle, tri_val(4'd5, 7'd0));
        tick(); expect_out("t5.s_done", 1'b0, 12'h000, 1'b0, 1'b1);
        tick();
        $display("stream model 2 then 5: held command");

        // Reset during the second triangle abandons the stream.
        issue_cmd(4'd2);
        tick(); expect_out("t6.o0", 1'b1, 12'h001, 1'b0, 1'b0);
        tick(); expect_out("t6.o1", 1'b1, 12'h002, 1'b0, 1'b0);
        #1 rstn = 1'b0;
        #1;
        check("t6.rst_valid", out_valid, 1'b0);
        check("t6.rst_last", out_last, 1'b0);
        check("t6.rst_idx", read_triangle_index, 7'd0);
        check("t6.rst_cmd_ready", cmd_ready, 1'b0);
        #1 rstn = 1'b1;
        #1 check("t6.idle_after", cmd_ready, 1'b1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("t6.no_done", done, 1'b0);
            check("t6.no_valid", out_valid, 1'b0);
        end
        issue_cmd(4'd2);
        tick(); expect_out("t6.r0", 1'b1, 12'h001, 1'b0, 1'b0);
        check("t6.r0_idx", read_triangle_index, 7'd1);
        tick(); expect_out("t6.r1", 1'b1, 12'h002, 1'b0, 1'b0);
        tick(); expect_out("t6.r2", 1'b1, 12'h003, 1'b1, 1'b0);
        tick(); expect_out("t6.r_done", 1'b0, 12'h000, 1'b0, 1'b1);
        $display("stream model 2: reset mid-stream, restarted");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
